// File: rtl/front_panel_switches.sv
// Front-panel switch conditioner: two-flop sync, counter debounce, rising-edge
// detect, priority capture into a one-entry pending slot, and a STOP bypass.
module front_panel_switches #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] sw_raw,
    input  logic [7:0] data_sw_raw,
    input  logic       busy,
    output logic [7:0] data_sw,
    output logic       examine,
    output logic       examine_next,
    output logic       deposit,
    output logic       deposit_next,
    output logic       step,
    output logic       run,
    output logic       stop,
    output logic       pending
);
    localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam int            STOP_BIT  = 6;

    logic [6:0]    sw_s1, sw_s2;
    logic [7:0]    data_s1, data_s2;
    logic [6:0]    deb, deb_q, edge_q;
    logic [CW-1:0] cnt [7];

    logic          slot_valid;
    logic [2:0]    slot_code;
    logic [5:0]    cmd_q;
    logic          stop_q;

    logic          emit;
    logic          stop_now;
    logic          any_cmd;
    logic [2:0]    pick;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        emit     = slot_valid & ~busy;
        stop_now = edge_q[STOP_BIT];
        any_cmd  = |edge_q[5:0];
        pick     = 3'd0;
        // Scan from lowest to highest priority so the highest-priority edge wins.
        for (int i = 5; i >= 0; i--) begin
            if (edge_q[i]) pick = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the counter array is reset like any other state; it is a handful of flops, not a RAM.
            sw_s1   <= '0;
            sw_s2   <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
            deb     <= '0;
            deb_q   <= '0;
            edge_q  <= '0;
            for (int i = 0; i < 7; i++) cnt[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sw_s1   <= sw_raw;
            sw_s2   <= sw_s1;
            data_s1 <= data_sw_raw;
            data_s2 <= data_s1;
            for (int i = 0; i < 7; i++) begin
                if (sw_s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sw_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            deb_q  <= deb;
            edge_q <= deb & ~deb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_valid <= 1'b0;
            slot_code  <= 3'd0;
            cmd_q      <= '0;
            stop_q     <= 1'b0;
        end else begin
            stop_q <= stop_now;
            cmd_q  <= (emit && !stop_now) ? (6'b000001 << slot_code) : 6'b000000;
            if (stop_now) begin
                slot_valid <= 1'b0;
            end else if (!slot_valid || emit) begin
                slot_valid <= any_cmd;
                slot_code  <= pick;
            end
        end
    end

    assign data_sw      = data_s2;
    assign examine      = cmd_q[0];
    assign examine_next = cmd_q[1];
    assign deposit      = cmd_q[2];
    assign deposit_next = cmd_q[3];
    assign step         = cmd_q[4];
    assign run          = cmd_q[5];
    assign stop         = stop_q;
    assign pending      = slot_valid;

endmodule

// File: tb/tb_front_panel_switches.sv
// Bench for front_panel_switches: directed timing scenarios plus a randomized
// run compared cycle-by-cycle against a sliding-window reference model.
module tb_front_panel_switches;
    localparam int N = 4;
    localparam bit [N-1:0] ALL1 = '1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] sw_raw = '0;
    logic [7:0] data_sw_raw = '0;
    logic       busy = 1'b0;
    logic [7:0] data_sw;
    logic       examine, examine_next, deposit, deposit_next, step, run, stop, pending;

    int errors = 0;
    int checks = 0;

    front_panel_switches #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw), .data_sw_raw(data_sw_raw),
        .busy(busy), .data_sw(data_sw), .examine(examine), .examine_next(examine_next),
        .deposit(deposit), .deposit_next(deposit_next), .step(step), .run(run),
        .stop(stop), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] cmds();
        return {run, step, deposit_next, deposit, examine_next, examine};
    endfunction

    function automatic logic [15:0] outs();
        return {data_sw, pending, stop, cmds()};
    endfunction

    // Reference model: a switch flips once its last N synchronised samples all
    // disagree with the debounced value; commands then flow through fixed delays.
    bit [6:0]   m_s1, m_s2, m_d, m_rise, m_e;
    bit [N-1:0] m_win [7];
    bit [7:0]   m_dat1, m_dat2;
    bit         m_valid, m_stop;
    int         m_code;
    bit [5:0]   m_cmd;

    task automatic model_step();
        bit [6:0] new_d;
        int pick;
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_d = '0; m_rise = '0; m_e = '0;
            m_dat1 = '0; m_dat2 = '0; m_valid = 0; m_stop = 0; m_code = 0; m_cmd = '0;
            for (int i = 0; i < 7; i++) m_win[i] = '0;
            return;
        end
        m_cmd = '0;
        if (m_valid && !busy && !m_e[6]) m_cmd[m_code] = 1'b1;
        m_stop = m_e[6];
        if (m_e[6]) begin
            m_valid = 0;
        end else if (!m_valid || !busy) begin
            pick = -1;
            for (int i = 0; i < 6; i++) if (pick < 0 && m_e[i]) pick = i;
            m_valid = (pick >= 0);
            if (pick >= 0) m_code = pick;
        end
        new_d = m_d;
        for (int i = 0; i < 7; i++) begin
            m_win[i] = {m_win[i][N-2:0], m_s2[i]};
            if (m_d[i] ? (m_win[i] == 0) : (m_win[i] == ALL1)) new_d[i] = ~m_d[i];
        end
        m_e    = m_rise;
        m_rise = new_d & ~m_d;
        m_d    = new_d;
        m_s2   = m_s1;
        m_s1   = sw_raw;
        m_dat2 = m_dat1;
        m_dat1 = data_sw_raw;
    endtask

    always @(posedge clk) model_step();

    task automatic settle();
        @(negedge clk);
        sw_raw = '0;
        busy   = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sw_raw = 7'h7F;
        data_sw_raw = 8'h3C;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (outs() !== 16'h0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0000", outs());
            end
        end
        sw_raw = '0;
        data_sw_raw = '0;
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (outs() !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected 0000", outs());
        end
    endtask

    task automatic test_clean_press();
        int first = -1, count = 0, others = 0;
        @(negedge clk);
        sw_raw[3] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (deposit_next) begin
                count++;
                if (first < 0) first = i - 1;
            end
            if ((cmds() & 6'b110111) != 0 || stop) others++;
        end
        checks++;
        if (first != 8) begin errors++; $display("FAIL clean_press_latency: got %0d expected 8", first); end
        checks++;
        if (count != 1) begin errors++; $display("FAIL clean_press_count: got %0d expected 1", count); end
        checks++;
        if (others != 0) begin errors++; $display("FAIL clean_press_others: got %0d expected 0", others); end
        sw_raw[3] = 1'b0;
        count = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cmds() != 0 || stop) count++;
        end
        checks++;
        if (count != 0) begin errors++; $display("FAIL release_no_pulse: got %0d expected 0", count); end
        settle();
    endtask

    task automatic test_bounce();
        logic [5:0] pattern = 6'b101101;
        int first = -1, count = 0;
        @(negedge clk);
        for (int i = 5; i >= 1; i--) begin
            sw_raw[0] = pattern[i];
            @(negedge clk);
            if (cmds() != 0) count++;
        end
        sw_raw[0] = pattern[0];
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (examine) begin
                count++;
                if (first < 0) first = i - 1;
            end
        end
        checks++;
        if (first != 8) begin errors++; $display("FAIL bounce_latency: got %0d expected 8", first); end
        checks++;
        if (count != 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", count); end
        settle();
    endtask

    task automatic test_busy_hold();
        int count = 0;
        @(negedge clk);
        busy = 1'b1;
        sw_raw[2] = 1'b1;
        repeat (10) begin @(negedge clk); if (cmds() != 0) count++; end
        sw_raw[4] = 1'b1;
        repeat (10) begin @(negedge clk); if (cmds() != 0) count++; end
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL busy_pending: got %b expected 1", pending); end
        checks++;
        if (count != 0) begin errors++; $display("FAIL busy_no_pulse: got %0d expected 0", count); end
        busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({deposit, step, pending} !== 3'b100) begin
            errors++;
            $display("FAIL busy_release: got deposit/step/pending=%b expected 100", {deposit, step, pending});
        end
        count = 0;
        repeat (12) begin @(negedge clk); if (cmds() != 0 || pending) count++; end
        checks++;
        if (count != 0) begin errors++; $display("FAIL busy_step_dropped: got %0d expected 0", count); end
        settle();
    endtask

    task automatic test_simultaneous();
        int en = 0, st = 0, other = 0;
        @(negedge clk);
        sw_raw[1] = 1'b1;
        sw_raw[4] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (examine_next) en++;
            if (step) st++;
            if ((cmds() & 6'b101101) != 0) other++;
        end
        checks++;
        if (en != 1) begin errors++; $display("FAIL simul_examine_next: got %0d expected 1", en); end
        checks++;
        if (st != 0 || other != 0) begin
            errors++;
            $display("FAIL simul_dropped: got step=%0d other=%0d expected 0 0", st, other);
        end
        settle();
    endtask

    task automatic test_stop_override();
        int first = -1, count = 0, cmdp = 0;
        logic pend_at_stop = 1'b1;
        @(negedge clk);
        busy = 1'b1;
        sw_raw[2] = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL stop_pre_pending: got %b expected 1", pending); end
        sw_raw[6] = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (stop) begin
                count++;
                if (first < 0) begin first = i - 1; pend_at_stop = pending; end
            end
            if (cmds() != 0) cmdp++;
        end
        checks++;
        if (first != 7) begin errors++; $display("FAIL stop_latency: got %0d expected 7", first); end
        checks++;
        if (count != 1) begin errors++; $display("FAIL stop_count: got %0d expected 1", count); end
        checks++;
        if (pend_at_stop !== 1'b0) begin errors++; $display("FAIL stop_clears_pending: got %b expected 0", pend_at_stop); end
        busy = 1'b0;
        repeat (12) begin @(negedge clk); if (cmds() != 0 || pending) cmdp++; end
        checks++;
        if (cmdp != 0) begin errors++; $display("FAIL stop_discard: got %0d expected 0", cmdp); end
        settle();
    endtask

    task automatic test_reset_mid();
        int count = 0;
        @(negedge clk);
        data_sw_raw = 8'hA5;
        busy = 1'b1;
        sw_raw[0] = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (pending !== 1'b1 || data_sw !== 8'hA5) begin
            errors++;
            $display("FAIL rst_mid_pre: got pending=%b data=%h expected 1 a5", pending, data_sw);
        end
        reset_n = 1'b0;
        sw_raw = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (outs() !== 16'h0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0000", outs()); end
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (data_sw !== 8'h00) begin errors++; $display("FAIL rst_mid_data1: got %h expected 00", data_sw); end
        @(negedge clk);
        checks++;
        if (data_sw !== 8'hA5) begin errors++; $display("FAIL rst_mid_data2: got %h expected a5", data_sw); end
        busy = 1'b0;
        repeat (15) begin @(negedge clk); if (cmds() != 0 || stop || pending) count++; end
        checks++;
        if (count != 0) begin errors++; $display("FAIL rst_mid_discard: got %0d expected 0", count); end
        data_sw_raw = '0;
        settle();
    endtask

    task automatic test_random();
        logic [15:0] exp_v;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_v = {m_dat2, m_valid, m_stop, m_cmd};
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", cyc, outs(), exp_v);
            end
            checks++;
            if ($countones(cmds()) > 1 || (stop && cmds() != 0)) begin
                errors++;
                $display("FAIL random_onehot%0d: got cmds=%b stop=%b expected at most one", cyc, cmds(), stop);
            end
            for (int b = 0; b < 7; b++) if ($urandom_range(11) == 0) sw_raw[b] = ~sw_raw[b];
            if ($urandom_range(5) == 0) busy = ~busy;
            data_sw_raw = 8'($urandom);
            reset_n = ($urandom_range(499) != 0);
        end
        reset_n = 1'b1;
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_busy_hold();
        test_simultaneous();
        test_stop_override();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
